// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU front end.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ISSUE   = 3'd0,
    OPCODE  = 3'd1,
    OPERAND = 3'd2,
    VALID   = 3'd3,
    HALTED  = 3'd4
  } fetch_state_e;

  localparam data_t HALT_OPCODE = 8'h7F;

  // Opcode MSB set marks a two-byte instruction.
  function automatic logic is_long(input data_t opcode);
    return opcode[DATA_W-1];
  endfunction
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: walks the PC over a synchronous-read memory, assembles
// 1/2-byte instructions and hands them to decode over valid/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
  parameter logic [DATA_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_len;
  logic [DATA_W-1:0] r_opcode, r_operand;
  logic [ADDR_W-1:0] r_instr_pc;

  assign w_pc_inc = r_pc + 1'b1;
  assign w_len    = is_long(r_opcode) ? ADDR_W'(2) : ADDR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    mem_address = r_pc;
    case (r_state)
      ISSUE:   w_state_nxt = OPCODE;
      OPCODE: begin
        // operand address goes out speculatively; ignored for 1-byte opcodes
        mem_address = w_pc_inc;
        w_state_nxt = is_long(mem_data_out) ? OPERAND : VALID;
      end
      OPERAND: begin
        mem_address = w_pc_inc;
        w_state_nxt = VALID;
      end
      VALID: begin
        if (instr_ready) begin
          w_pc_nxt    = r_pc + w_len;
          w_state_nxt = (r_opcode == HALT_OPCODE) ? HALTED : ISSUE;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = ISSUE;
    endcase
    // redirect beats everything, including a handshake in the same cycle
    if (jump_en) begin
      w_state_nxt = ISSUE;
      w_pc_nxt    = jump_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ISSUE;
      r_pc       <= RESET_PC;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (!jump_en) begin
        if (r_state == OPCODE) begin
          r_opcode   <= mem_data_out;
          r_instr_pc <= r_pc;
          if (!is_long(mem_data_out)) r_operand <= '0;
        end
        if (r_state == OPERAND) r_operand <= mem_data_out;
      end
    end
  end

  assign mem_wen       = 1'b0;
  assign instr_valid   = (r_state == VALID);
  assign halted        = (r_state == HALTED);
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_pc      = r_instr_pc;

endmodule
